// File: rtl/eth_inserter_ctrl_pkg.sv
// Shared types and defaults for the header-inserter deadlock recovery controller.
package eth_inserter_ctrl_pkg;

   localparam int unsigned DEF_BLOCK_THRESH = 256;
   localparam int unsigned DEF_FLUSH_CYCLES = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_SUSPECT = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_DRAIN   = 3'd4
   } ctrl_state_e;

endpackage

// File: rtl/eth_inserter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment in one cycle yields 1.
module eth_inserter_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = inc_i ? W'(1) : '0;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_inserter_deadlock_recovery_ctrl.sv
// Run/recovery controller for the header-inserter kernel: detects a sustained
// block indication, pulses a soft reset, holds upstream while draining, then resumes.
module eth_inserter_deadlock_recovery_ctrl
   import eth_inserter_ctrl_pkg::*;
#(
   parameter int unsigned BLOCK_THRESH = DEF_BLOCK_THRESH,
   parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        block_in,
   input  logic        kern_idle,
   output logic        kern_start,
   output logic        kern_reset,
   output logic        in_hold,
   input  logic        clr_stats,
   output logic [15:0] dl_count,
   output logic        dl_sticky,
   output logic [2:0]  state_o
);

   localparam logic [15:0] THRESH     = 16'(BLOCK_THRESH);
   localparam logic [7:0]  FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

   ctrl_state_e state_q, state_d;
   logic [15:0] susp_cnt_q, susp_cnt_d;
   logic [7:0]  flush_cnt_q, flush_cnt_d;
   logic        kern_start_q, kern_reset_q, in_hold_q, dl_sticky_q;
   logic        recover;

   always_comb begin
      state_d     = state_q;
      susp_cnt_d  = susp_cnt_q;
      flush_cnt_d = flush_cnt_q;
      recover     = 1'b0;
      case (state_q)
         ST_IDLE: if (enable) state_d = ST_RUN;
         ST_RUN: begin
            // block_in takes priority over a pending disable
            if (block_in) begin
               state_d    = ST_SUSPECT;
               susp_cnt_d = 16'd1;
            end else if (!enable && kern_idle) begin
               state_d = ST_IDLE;
            end
         end
         ST_SUSPECT: begin
            if (!block_in) begin
               state_d    = ST_RUN;
               susp_cnt_d = '0;
            end else if (susp_cnt_q + 16'd1 == THRESH) begin
               state_d     = ST_FLUSH;
               susp_cnt_d  = '0;
               flush_cnt_d = '0;
               recover     = 1'b1;
            end else begin
               susp_cnt_d = susp_cnt_q + 16'd1;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == FLUSH_LAST) begin
               state_d     = ST_DRAIN;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q + 8'd1;
            end
         end
         ST_DRAIN: if (kern_idle) state_d = enable ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they align with state_q.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         susp_cnt_q   <= '0;
         flush_cnt_q  <= '0;
         kern_start_q <= 1'b0;
         kern_reset_q <= 1'b0;
         in_hold_q    <= 1'b0;
         dl_sticky_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         susp_cnt_q   <= susp_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         kern_start_q <= ((state_d == ST_RUN) && enable) || (state_d == ST_SUSPECT);
         kern_reset_q <= (state_d == ST_FLUSH);
         in_hold_q    <= (state_d == ST_FLUSH) || (state_d == ST_DRAIN);
         if (clr_stats)
            dl_sticky_q <= recover;
         else if (recover)
            dl_sticky_q <= 1'b1;
      end
   end

   eth_inserter_sat_counter #(.W(16)) u_dl_cnt (
      .clock (clock),
      .reset (reset),
      .inc_i (recover),
      .clr_i (clr_stats),
      .cnt_o (dl_count)
   );

   assign kern_start = kern_start_q;
   assign kern_reset = kern_reset_q;
   assign in_hold    = in_hold_q;
   assign dl_sticky  = dl_sticky_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_eth_inserter_deadlock_recovery_ctrl.sv
// Scoreboard bench: a behavioral model pushes expected outputs per cycle, popped after each edge.
module tb_eth_inserter_deadlock_recovery_ctrl;
   import eth_inserter_ctrl_pkg::*;

   localparam int BT = 8;
   localparam int FC = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0, block_in = 1'b0, kern_idle = 1'b0, clr_stats = 1'b0;
   logic        kern_start, kern_reset, in_hold, dl_sticky;
   logic [15:0] dl_count;
   logic [2:0]  state_o;

   typedef struct packed {
      logic [2:0]  st;
      logic        ks;
      logic        kr;
      logic        ih;
      logic [15:0] cnt;
      logic        sticky;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0, n_err = 0;

   ctrl_state_e m_state;
   int          m_streak, m_left;
   logic [15:0] m_cnt;
   logic        m_sticky;

   eth_inserter_deadlock_recovery_ctrl #(.BLOCK_THRESH(BT), .FLUSH_CYCLES(FC)) dut (
      .clock(clock), .reset(reset), .enable(enable), .block_in(block_in),
      .kern_idle(kern_idle), .kern_start(kern_start), .kern_reset(kern_reset),
      .in_hold(in_hold), .clr_stats(clr_stats), .dl_count(dl_count),
      .dl_sticky(dl_sticky), .state_o(state_o)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = ST_IDLE; m_streak = 0; m_left = 0; m_cnt = '0; m_sticky = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".state"}, 16'(state_o), 16'(ST_IDLE));
      chk({tag, ".kstart"}, 16'(kern_start), 16'd0);
      chk({tag, ".kreset"}, 16'(kern_reset), 16'd0);
      chk({tag, ".hold"}, 16'(in_hold), 16'd0);
      chk({tag, ".cnt"}, dl_count, 16'd0);
      chk({tag, ".sticky"}, 16'(dl_sticky), 16'd0);
   endtask

   task automatic step(input string tag, input logic en, input logic blk,
                       input logic idle, input logic clr);
      logic rec;
      exp_t e;
      enable = en; block_in = blk; kern_idle = idle; clr_stats = clr;
      rec = 1'b0;
      case (m_state)
         ST_IDLE: if (en) m_state = ST_RUN;
         ST_RUN: begin
            if (blk) begin m_state = ST_SUSPECT; m_streak = 1; end
            else if (!en && idle) m_state = ST_IDLE;
         end
         ST_SUSPECT: begin
            if (!blk) begin m_state = ST_RUN; m_streak = 0; end
            else begin
               m_streak++;
               if (m_streak == BT) begin
                  m_state = ST_FLUSH; m_streak = 0; m_left = FC; rec = 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            m_left--;
            if (m_left == 0) m_state = ST_DRAIN;
         end
         ST_DRAIN: if (idle) m_state = en ? ST_RUN : ST_IDLE;
         default: m_state = ST_IDLE;
      endcase
      if (clr) begin
         m_cnt = rec ? 16'd1 : 16'd0;
         m_sticky = rec;
      end else if (rec) begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         m_sticky = 1'b1;
      end
      e.st     = m_state;
      e.ks     = ((m_state == ST_RUN) && en) || (m_state == ST_SUSPECT);
      e.kr     = (m_state == ST_FLUSH);
      e.ih     = (m_state == ST_FLUSH) || (m_state == ST_DRAIN);
      e.cnt    = m_cnt;
      e.sticky = m_sticky;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, ".sb_empty"}, 16'd1, 16'd0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ".state"}, 16'(state_o), 16'(e.st));
         chk({tag, ".kstart"}, 16'(kern_start), 16'(e.ks));
         chk({tag, ".kreset"}, 16'(kern_reset), 16'(e.kr));
         chk({tag, ".hold"}, 16'(in_hold), 16'(e.ih));
         chk({tag, ".cnt"}, dl_count, e.cnt);
         chk({tag, ".sticky"}, 16'(dl_sticky), 16'(e.sticky));
      end
   endtask

   // Full deadlock, flush, two drain cycles, resume; optional clr on the detecting cycle.
   task automatic recover_cycle(input string tag, input logic clr_last);
      repeat (BT - 1) step({tag, ".blk"}, 1'b1, 1'b1, 1'b0, 1'b0);
      step({tag, ".det"}, 1'b1, 1'b1, 1'b0, clr_last);
      repeat (FC) step({tag, ".flush"}, 1'b1, 1'b1, 1'b0, 1'b0);
      step({tag, ".drain"}, 1'b1, 1'b0, 1'b0, 1'b0);
      step({tag, ".resume"}, 1'b1, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      model_reset();
      #1 chk_reset("rst_init");
      #2 reset = 1'b0;

      // start-up
      repeat (3) step("start", 1'b1, 1'b0, 1'b0, 1'b0);

      // sub-threshold block burst
      repeat (BT - 1) step("short_blk", 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) step("short_rel", 1'b1, 1'b0, 1'b0, 1'b0);

      // first recovery
      recover_cycle("rec1", 1'b0);
      step("rec1.run", 1'b1, 1'b0, 1'b0, 1'b0);

      // saturation: preload near the top
      force dut.u_dl_cnt.cnt_q = 16'hFFFE;
      #1 release dut.u_dl_cnt.cnt_q;
      m_cnt = 16'hFFFE;
      recover_cycle("sat1", 1'b0);
      recover_cycle("sat2", 1'b0);
      recover_cycle("clr_inc", 1'b1);
      step("clr_only", 1'b1, 1'b0, 1'b0, 1'b1);

      // disable during SUSPECT does not abort; disable in DRAIN goes IDLE
      step("dis_susp", 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (BT - 1) step("dis_susp.blk", 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (FC) step("dis_flush", 1'b0, 1'b0, 1'b0, 1'b0);
      step("drain_idle", 1'b0, 1'b0, 1'b1, 1'b0);
      step("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0);

      // disable from RUN waits for kern_idle
      step("run_again", 1'b1, 1'b0, 1'b0, 1'b0);
      step("run_wait", 1'b0, 1'b0, 1'b0, 1'b0);
      step("run_wait2", 1'b0, 1'b0, 1'b0, 1'b0);
      step("run_to_idle", 1'b0, 1'b0, 1'b1, 1'b0);

      // async reset in FLUSH cycle 2
      step("rf.start", 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (BT) step("rf.blk", 1'b1, 1'b1, 1'b0, 1'b0);
      step("rf.flush2", 1'b1, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      #1 chk_reset("rst_flush");
      model_reset();
      sb_q.delete();
      #1 reset = 1'b0;
      repeat (3) step("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
